// File: rtl/data_line_fill.sv
// Cache data line with a built-in critical-word-first refill engine.
// A per-word valid mask lets the pipeline restart on the critical word before the line fill completes.
module data_line_fill #(
  parameter int WIDTH = 16,
  parameter int WORDS = 8,
  parameter int IDX_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               wen,
  input  logic [IDX_W-1:0]   word_idx,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               word_ready,
  input  logic               fill_start,
  input  logic [IDX_W-1:0]   fill_base_idx,
  input  logic               mem_valid,
  input  logic [WIDTH-1:0]   mem_data,
  output logic               fill_busy,
  output logic               fill_done,
  output logic [IDX_W:0]     fill_count,
  output logic [WORDS-1:0]   word_valid
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam int unsigned    LAST     = WORDS - 1;
  localparam logic [IDX_W:0] LAST_CNT = LAST[IDX_W:0];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] words_q [WORDS];
  logic [WIDTH-1:0] words_d [WORDS];
  logic [WORDS-1:0] valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   count_q, count_d;

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    count_d = count_q;

    // CPU writes are only dropped while filling; an IDLE write alongside fill_start still lands.
    if (enable && wen && (state_q != FILL)) begin
      words_d[word_idx] = data_in;
    end

    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = FILL;
          ptr_d   = fill_base_idx;
          count_d = '0;
          valid_d = '0;
        end
      end
      FILL: begin
        if (mem_valid) begin
          words_d[ptr_q] = mem_data;
          valid_d[ptr_q] = 1'b1;
          ptr_d          = ptr_q + 1'b1;
          count_d        = count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '1;
      ptr_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < WORDS; i++) begin
        words_q[i] <= words_d[i];
      end
    end
  end

  assign data_out   = enable ? words_q[word_idx] : '0;
  assign word_ready = valid_q[word_idx] & enable;
  assign fill_busy  = (state_q == FILL);
  assign fill_done  = (state_q == DONE);
  assign fill_count = count_q;
  assign word_valid = valid_q;

endmodule

// File: tb/tb_data_line_fill.sv
// Directed bench for data_line_fill: reset, CPU access, aligned and wrapped refills, hazards, reset mid-fill.
module tb_data_line_fill;

  logic        clk = 1'b0;
  logic        rst, enable, wen, fill_start, mem_valid;
  logic [2:0]  word_idx, fill_base_idx;
  logic [15:0] data_in, mem_data, data_out;
  logic        word_ready, fill_busy, fill_done;
  logic [3:0]  fill_count;
  logic [7:0]  word_valid;

  int n_checks = 0;
  int n_fail   = 0;

  data_line_fill #(.WIDTH(16), .WORDS(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wen(wen), .word_idx(word_idx),
    .data_in(data_in), .data_out(data_out), .word_ready(word_ready),
    .fill_start(fill_start), .fill_base_idx(fill_base_idx), .mem_valid(mem_valid),
    .mem_data(mem_data), .fill_busy(fill_busy), .fill_done(fill_done),
    .fill_count(fill_count), .word_valid(word_valid)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input int idx, input logic [15:0] exp);
    word_idx = 3'(idx);
    #1;
    check_eq(tag, {16'h0, data_out}, {16'h0, exp});
  endtask

  task automatic beat(input logic [15:0] d);
    mem_valid = 1'b1;
    mem_data  = d;
    step();
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_v;
    rst = 1'b1; enable = 1'b0; wen = 1'b0; word_idx = '0; data_in = '0;
    fill_start = 1'b0; fill_base_idx = '0; mem_valid = 1'b0; mem_data = '0;
    step();
    rst = 1'b0;

    // 1. reset state
    enable = 1'b1;
    check_eq("rst_valid", {24'h0, word_valid}, 32'hFF);
    check_eq("rst_busy", {31'h0, fill_busy}, 32'h0);
    check_eq("rst_done", {31'h0, fill_done}, 32'h0);
    check_eq("rst_count", {28'h0, fill_count}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      read_chk("rst_data", i, 16'h0000);
      check_eq("rst_ready", {31'h0, word_ready}, 32'h1);
    end

    // 2. CPU write / read
    wen = 1'b1; word_idx = 3'd3; data_in = 16'hA5A5; step();
    word_idx = 3'd7; data_in = 16'h1234; step();
    wen = 1'b0;
    read_chk("cpu_rd3", 3, 16'hA5A5);
    read_chk("cpu_rd7", 7, 16'h1234);
    enable = 1'b0;
    read_chk("dis_rd3", 3, 16'h0000);
    check_eq("dis_ready", {31'h0, word_ready}, 32'h0);
    wen = 1'b1; word_idx = 3'd3; data_in = 16'hFFFF; step();
    wen = 1'b0; enable = 1'b1;
    read_chk("dis_wr3", 3, 16'hA5A5);

    // 3. aligned back-to-back fill
    fill_start = 1'b1; fill_base_idx = 3'd0; step();
    fill_start = 1'b0;
    check_eq("al_busy0", {31'h0, fill_busy}, 32'h1);
    check_eq("al_valid0", {24'h0, word_valid}, 32'h0);
    check_eq("al_count0", {28'h0, fill_count}, 32'h0);
    mem_valid = 1'b1;
    exp_v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mem_data = 16'h1000 + 16'(i);
      step();
      exp_v = exp_v | (8'h01 << i);
      check_eq("al_valid", {24'h0, word_valid}, {24'h0, exp_v});
      check_eq("al_count", {28'h0, fill_count}, 32'(i + 1));
      check_eq("al_busy", {31'h0, fill_busy}, (i < 7) ? 32'h1 : 32'h0);
      check_eq("al_done", {31'h0, fill_done}, (i == 7) ? 32'h1 : 32'h0);
    end
    mem_valid = 1'b0;
    step();
    check_eq("al_done_end", {31'h0, fill_done}, 32'h0);
    check_eq("al_count_hold", {28'h0, fill_count}, 32'h8);
    for (int i = 0; i < 8; i++) read_chk("al_word", i, 16'h1000 + 16'(i));

    // 4. critical word first, base 5, 2-cycle stall after 2nd beat
    fill_start = 1'b1; fill_base_idx = 3'd5; step();
    fill_start = 1'b0;
    word_idx = 3'd5; #1;
    check_eq("cw_ready_pre", {31'h0, word_ready}, 32'h0);
    beat(16'h00B0);
    read_chk("cw_crit", 5, 16'h00B0);
    check_eq("cw_ready5", {31'h0, word_ready}, 32'h1);
    beat(16'h00B1);
    for (int s = 0; s < 2; s++) begin
      step();
      check_eq("cw_stall_cnt", {28'h0, fill_count}, 32'h2);
      check_eq("cw_stall_vld", {24'h0, word_valid}, 32'h60);
    end
    for (int k = 2; k < 8; k++) beat(16'h00B0 + 16'(k));
    check_eq("cw_done", {31'h0, fill_done}, 32'h1);
    for (int k = 0; k < 8; k++) read_chk("cw_word", (5 + k) % 8, 16'h00B0 + 16'(k));
    step();

    // 5. hazards during fill
    fill_start = 1'b1; fill_base_idx = 3'd0; step();
    fill_start = 1'b0;
    beat(16'h2000);
    beat(16'h2001);
    wen = 1'b1; word_idx = 3'd2; data_in = 16'hDEAD;
    fill_start = 1'b1; fill_base_idx = 3'd6; step();
    wen = 1'b0; fill_start = 1'b0;
    check_eq("hz_count", {28'h0, fill_count}, 32'h2);
    read_chk("hz_drop", 2, 16'h00B5);
    check_eq("hz_ready2", {31'h0, word_ready}, 32'h0);
    for (int k = 2; k < 8; k++) beat(16'h2000 + 16'(k));
    check_eq("hz_done", {31'h0, fill_done}, 32'h1);
    check_eq("hz_cnt8", {28'h0, fill_count}, 32'h8);
    read_chk("hz_w2", 2, 16'h2002);
    read_chk("hz_w6", 6, 16'h2006);
    step();
    wen = 1'b1; word_idx = 3'd4; data_in = 16'hBEEF;
    fill_start = 1'b1; fill_base_idx = 3'd4; step();
    wen = 1'b0; fill_start = 1'b0;
    read_chk("sim_wr", 4, 16'hBEEF);
    check_eq("sim_ready0", {31'h0, word_ready}, 32'h0);
    beat(16'h3000);
    read_chk("sim_over", 4, 16'h3000);
    check_eq("sim_ready1", {31'h0, word_ready}, 32'h1);
    for (int k = 1; k < 8; k++) beat(16'h3000 + 16'(k));
    check_eq("sim_done", {31'h0, fill_done}, 32'h1);
    read_chk("sim_w3", 3, 16'h3007);
    step();

    // 6. reset mid-fill, then a clean fill
    fill_start = 1'b1; fill_base_idx = 3'd0; step();
    fill_start = 1'b0;
    for (int k = 0; k < 3; k++) beat(16'h4000 + 16'(k));
    rst = 1'b1; mem_valid = 1'b1; mem_data = 16'h4003; step();
    rst = 1'b0; mem_valid = 1'b0;
    check_eq("mr_valid", {24'h0, word_valid}, 32'hFF);
    check_eq("mr_busy", {31'h0, fill_busy}, 32'h0);
    check_eq("mr_count", {28'h0, fill_count}, 32'h0);
    for (int i = 0; i < 8; i++) read_chk("mr_word", i, 16'h0000);
    for (int s = 0; s < 3; s++) begin
      check_eq("mr_nodone", {31'h0, fill_done}, 32'h0);
      step();
    end
    fill_start = 1'b1; fill_base_idx = 3'd3; step();
    fill_start = 1'b0;
    for (int k = 0; k < 8; k++) beat(16'h5000 + 16'(k));
    check_eq("rf_done", {31'h0, fill_done}, 32'h1);
    check_eq("rf_valid", {24'h0, word_valid}, 32'hFF);
    read_chk("rf_w3", 3, 16'h5000);
    read_chk("rf_w2", 2, 16'h5007);
    step();
    check_eq("rf_idle", {31'h0, fill_done | fill_busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_line_fill.md
Name: data_line_fill

Overview:
- Parametrised cache data line: WORDS registers of WIDTH bits each, addressed by a binary word index.
- Adds a built-in refill engine that loads the whole line from memory, critical word first, wrapping modulo WORDS.
- Tracks a per-word valid mask so the pipeline can restart early on the critical word.
- Sits inside the D-cache and I-cache data arrays, one instance per line, driven by the cache miss controller.

Parameters:
WIDTH, 16, bits per word
WORDS, 8, words per line (power of two, >=2)
IDX_W, 3, word index width; must equal log2(WORDS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
enable  in  1  line selected by set/way decode
wen  in  1  CPU write request (qualified by enable)
word_idx  in  IDX_W  word index for CPU read/write
data_in  in  WIDTH  CPU write data
data_out  out  WIDTH  word[word_idx] when enable, else 0
word_ready  out  1  word_valid[word_idx] & enable
fill_start  in  1  begin line refill
fill_base_idx  in  IDX_W  first (critical) word of refill
mem_valid  in  1  mem_data carries next refill word
mem_data  in  WIDTH  refill data from memory
fill_busy  out  1  high in FILL state
fill_done  out  1  one-cycle pulse in DONE state
fill_count  out  IDX_W+1  words received in current refill
word_valid  out  WORDS  per-word valid mask

Behaviour:
- Reset (rst=1 at edge): all words=0, word_valid=all ones, state=IDLE, ptr=0, fill_count=0, fill_busy=0, fill_done=0. Reset dominates every other input, including mid-fill.
- Read path is combinational with zero latency: data_out = enable ? word[word_idx] : 0. No bypass; a word written at edge N appears after edge N.
- CPU write: at the edge where enable & wen & !fill_busy, word[word_idx] <= data_in. CPU writes while fill_busy=1 are dropped, with no effect on any state.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - fill_start=1: next state FILL; ptr <= fill_base_idx; fill_count <= 0; word_valid <= 0.
  - If a CPU write coincides with fill_start in IDLE, the write is performed (fill_busy is still 0); the refill later overwrites that word.
- FILL, on each mem_valid=1 edge:
  - word[ptr] <= mem_data; word_valid[ptr] <= 1.
  - ptr <= (ptr+1) mod WORDS; fill_count += 1.
  - mem_valid=0 cycles are stalls: nothing changes.
  - When mem_valid=1 and fill_count==WORDS-1, the last word is written and the next state is DONE (fill_count becomes WORDS).
- DONE: fill_done=1 and fill_busy=0 for exactly one cycle; next state is IDLE. fill_count holds WORDS until the next fill_start.
- fill_start asserted in FILL or DONE is ignored. mem_valid in IDLE or DONE is ignored.
- The wrap-around order is fixed: base, base+1, …, WORDS-1, 0, …, base-1.
- word_ready lets the consumer take the critical word the cycle after it arrives, while the fill continues.
- Reset mid-fill: line returns to reset values with word_valid all ones. The controller must also invalidate the tag; that is not this block's job.
- Outputs fill_busy, fill_done, fill_count and word_valid are registered-state decodes; no combinational path from mem_valid to them.

Test Plan:
1. Reset then reads: rst 1 cycle; enable=1, sweep word_idx 0..7 -> data_out=0x0000, word_ready=1, word_valid=0xFF, fill_busy=0.
2. CPU write/read:
   - Write 0xA5A5 to idx 3 and 0x1234 to idx 7 -> read back exact values.
   - With enable=0 -> data_out=0.
   - Write with enable=0 -> no change.
3. Aligned fill, back-to-back:
   - fill_start with base=0, then 8 consecutive mem_valid beats with data 0x1000..0x1007.
   - Required: fill_busy high for 8 cycles, word_valid goes 0x01, 0x03 … 0xFF.
   - fill_done pulses once on the cycle after the 8th beat; fill_count=8; word[i]=0x1000+i.
4. Critical-word-first with stalls:
   - base=5, beats 0xB0..0xB7 with a 2-cycle gap after the 2nd beat.
   - Required: word5=0xB0, word6=0xB1, word7=0xB2, word0=0xB3 … word4=0xB7.
   - Stall cycles leave fill_count unchanged; word_ready at idx 5 is high one cycle after the first beat.
5. Hazards during fill:
   - CPU write 0xDEAD to idx 2 mid-fill -> dropped; word2 holds its refill value.
   - A second fill_start mid-fill -> ignored; ptr and fill_count undisturbed.
   - A simultaneous IDLE write plus fill_start -> write lands, then gets overwritten by the refill.
6. Reset mid-fill: assert rst after 3 beats -> next cycle all words=0, word_valid=0xFF, fill_busy=0, fill_done never pulses; a subsequent full fill completes normally.
